// File: rtl/dmac_axi_sram.sv
// dmac_axi_sram
//   AXI3 slave SRAM that serves the DMAC master's read bursts (source fetch)
//   and write bursts (destination store). The read and write channels are
//   independent FSMs. They share one word-addressed store that has one read
//   port and one write port. Each direction allows one outstanding burst,
//   with no interleaving.
//
//   Optional feature macro: AXI_SRAM_ERR_EN
//     defined   : out-of-range beats, unsupported size, or burst type 10/11
//                 return SLVERR. Erroring write beats are accepted but dropped.
//                 Erroring read beats return zero data.
//     undefined : upper address bits alias modulo the memory size. Size and
//                 burst type are treated as 4-byte INCR (FIXED is still
//                 honoured). Every response is OKAY.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   aw*_i / awready_o     write address channel (id, addr, len, size, burst)
//   w*_i  / wready_o      write data channel (wid_i and wlast_i are ignored)
//   bid_o, bresp_o, bvalid_o / bready_i      write response channel
//   ar*_i / arready_o     read address channel
//   rid_o, rdata_o, rresp_o, rlast_o, rvalid_o / rready_i   read data channel
module dmac_axi_sram #(
  parameter int MEM_DEPTH_LOG2 = 14,
  parameter int ID_W           = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ID_W-1:0] awid_i,
  input  logic [31:0]     awaddr_i,
  input  logic [3:0]      awlen_i,
  input  logic [2:0]      awsize_i,
  input  logic [1:0]      awburst_i,
  input  logic            awvalid_i,
  output logic            awready_o,
  input  logic [ID_W-1:0] wid_i,
  input  logic [31:0]     wdata_i,
  input  logic [3:0]      wstrb_i,
  input  logic            wlast_i,
  input  logic            wvalid_i,
  output logic            wready_o,
  output logic [ID_W-1:0] bid_o,
  output logic [1:0]      bresp_o,
  output logic            bvalid_o,
  input  logic            bready_i,
  input  logic [ID_W-1:0] arid_i,
  input  logic [31:0]     araddr_i,
  input  logic [3:0]      arlen_i,
  input  logic [2:0]      arsize_i,
  input  logic [1:0]      arburst_i,
  input  logic            arvalid_i,
  output logic            arready_o,
  output logic [ID_W-1:0] rid_o,
  output logic [31:0]     rdata_o,
  output logic [1:0]      rresp_o,
  output logic            rlast_o,
  output logic            rvalid_o,
  input  logic            rready_i
);

  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int AW    = MEM_DEPTH_LOG2;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

  // ---------------- write channel state ----------------
  wstate_t         r_wstate, w_wstate_next;
  logic [ID_W-1:0] r_bid, w_bid_next;
  logic [31:0]     r_waddr, w_waddr_next;
  logic [3:0]      r_wlen, w_wlen_next;
  logic [3:0]      r_wcnt, w_wcnt_next;
  logic            r_wfixed, w_wfixed_next;
  logic            r_wbad, w_wbad_next;
  logic            r_werr, w_werr_next;
  logic            r_awready, r_wready, r_bvalid;
  logic            w_aw_hs, w_w_hs, w_b_hs;
  logic            w_aw_bad, w_wbeat_err, w_mem_we;
  logic [AW-1:0]   w_wr_idx;

  // ---------------- read channel state ----------------
  rstate_t         r_rstate, w_rstate_next;
  logic [ID_W-1:0] r_rid, w_rid_next;
  logic [31:0]     r_raddr, w_raddr_next;
  logic [3:0]      r_rlen, w_rlen_next;
  logic [3:0]      r_rcnt, w_rcnt_next;
  logic            r_rfixed, w_rfixed_next;
  logic            r_rbad, w_rbad_next;
  logic            r_rlast, w_rlast_next;
  logic            r_arready, r_rvalid;
  logic [31:0]     r_rdata;
  logic [1:0]      r_rresp;
  logic            w_ar_hs, w_r_hs, w_rload;
  logic            w_ar_bad, w_rbeat_err;
  logic [31:0]     w_rd_addr;
  logic [AW-1:0]   w_rd_idx;
  logic [31:0]     w_rd_word;
  logic            w_unused;

  assign w_aw_hs = awvalid_i & r_awready;
  assign w_w_hs  = wvalid_i & r_wready;
  assign w_b_hs  = r_bvalid & bready_i;
  assign w_ar_hs = arvalid_i & r_arready;
  assign w_r_hs  = r_rvalid & rready_i;

  // The address of the beat being loaded into rdata_o. It is the incoming
  // AR address on the first beat and the running burst address afterwards.
  assign w_rd_addr = (r_rstate == R_IDLE) ? araddr_i : r_raddr;
  assign w_rd_idx  = w_rd_addr[AW+1:2];
  assign w_wr_idx  = r_waddr[AW+1:2];

`ifdef AXI_SRAM_ERR_EN
  assign w_aw_bad    = (awsize_i != 3'b010) || awburst_i[1];
  assign w_ar_bad    = (arsize_i != 3'b010) || arburst_i[1];
  assign w_wbeat_err = r_wbad || (|r_waddr[31:AW+2]);
  assign w_rbeat_err = ((r_rstate == R_IDLE) ? w_ar_bad : r_rbad)
                       || (|w_rd_addr[31:AW+2]);
  assign w_unused    = ^{wid_i, wlast_i};
`else
  assign w_aw_bad    = 1'b0;
  assign w_ar_bad    = 1'b0;
  assign w_wbeat_err = 1'b0;
  assign w_rbeat_err = 1'b0;
  assign w_unused    = ^{wid_i, wlast_i, awsize_i, arsize_i, r_wbad, r_rbad};
`endif

  // Erroring write beats are still handshaken but never reach the array.
  assign w_mem_we = (r_wstate == W_DATA) && w_w_hs && !w_wbeat_err;

  // Storage is split into four byte lanes so that byte enables map onto
  // independent write ports. The array is not reset.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_lane [0:DEPTH-1];
      always_ff @(posedge clk) begin
        if (w_mem_we && wstrb_i[gi]) r_lane[w_wr_idx] <= wdata_i[8*gi +: 8];
      end
      assign w_rd_word[8*gi +: 8] = r_lane[w_rd_idx];
    end
  endgenerate

  // ---------------- write FSM ----------------
  always_comb begin
    w_wstate_next = r_wstate;
    w_bid_next    = r_bid;
    w_waddr_next  = r_waddr;
    w_wlen_next   = r_wlen;
    w_wcnt_next   = r_wcnt;
    w_wfixed_next = r_wfixed;
    w_wbad_next   = r_wbad;
    w_werr_next   = r_werr;
    case (r_wstate)
      W_IDLE: if (w_aw_hs) begin
        w_bid_next    = awid_i;
        w_waddr_next  = awaddr_i;
        w_wlen_next   = awlen_i;
        w_wfixed_next = (awburst_i == 2'b00);
        w_wbad_next   = w_aw_bad;
        w_werr_next   = 1'b0;
        w_wcnt_next   = 4'd0;
        w_wstate_next = W_DATA;
      end
      W_DATA: if (w_w_hs) begin
        w_werr_next  = r_werr | w_wbeat_err;
        w_waddr_next = r_waddr + (r_wfixed ? 32'd0 : 32'd4);
        w_wcnt_next  = r_wcnt + 4'd1;
        // The beat count is authoritative. wlast_i is not consulted.
        if (r_wcnt == r_wlen) w_wstate_next = W_RESP;
      end
      W_RESP: if (w_b_hs) w_wstate_next = W_IDLE;
      default: w_wstate_next = W_IDLE;
    endcase
  end

  // Handshake outputs are registered decodes of the next state. They therefore
  // stay low while in reset and rise on the first clock after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_bid     <= '0;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
      r_wfixed  <= 1'b0;
      r_wbad    <= 1'b0;
      r_werr    <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_wstate  <= w_wstate_next;
      r_bid     <= w_bid_next;
      r_waddr   <= w_waddr_next;
      r_wlen    <= w_wlen_next;
      r_wcnt    <= w_wcnt_next;
      r_wfixed  <= w_wfixed_next;
      r_wbad    <= w_wbad_next;
      r_werr    <= w_werr_next;
      r_awready <= (w_wstate_next == W_IDLE);
      r_wready  <= (w_wstate_next == W_DATA);
      r_bvalid  <= (w_wstate_next == W_RESP);
    end
  end

  // ---------------- read FSM ----------------
  always_comb begin
    w_rstate_next = r_rstate;
    w_rid_next    = r_rid;
    w_raddr_next  = r_raddr;
    w_rlen_next   = r_rlen;
    w_rcnt_next   = r_rcnt;
    w_rfixed_next = r_rfixed;
    w_rbad_next   = r_rbad;
    w_rlast_next  = r_rlast;
    w_rload       = 1'b0;
    case (r_rstate)
      R_IDLE: if (w_ar_hs) begin
        w_rid_next    = arid_i;
        w_rlen_next   = arlen_i;
        w_rfixed_next = (arburst_i == 2'b00);
        w_rbad_next   = w_ar_bad;
        w_rcnt_next   = 4'd0;
        // r_raddr always points at the beat to be fetched next.
        w_raddr_next  = araddr_i + ((arburst_i == 2'b00) ? 32'd0 : 32'd4);
        w_rlast_next  = (arlen_i == 4'd0);
        w_rload       = 1'b1;
        w_rstate_next = R_DATA;
      end
      R_DATA: if (w_r_hs) begin
        if (r_rcnt == r_rlen) begin
          w_rlast_next  = 1'b0;
          w_rstate_next = R_IDLE;
        end else begin
          w_rcnt_next  = r_rcnt + 4'd1;
          w_raddr_next = r_raddr + (r_rfixed ? 32'd0 : 32'd4);
          w_rlast_next = ((r_rcnt + 4'd1) == r_rlen);
          w_rload      = 1'b1;
        end
      end
      default: w_rstate_next = R_IDLE;
    endcase
  end

  // rdata_o is loaded from the array at the same edge as any write commit.
  // A colliding read therefore returns the value held before the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_rid     <= '0;
      r_raddr   <= '0;
      r_rlen    <= '0;
      r_rcnt    <= '0;
      r_rfixed  <= 1'b0;
      r_rbad    <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= 2'b00;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
    end else begin
      r_rstate  <= w_rstate_next;
      r_rid     <= w_rid_next;
      r_raddr   <= w_raddr_next;
      r_rlen    <= w_rlen_next;
      r_rcnt    <= w_rcnt_next;
      r_rfixed  <= w_rfixed_next;
      r_rbad    <= w_rbad_next;
      r_rlast   <= w_rlast_next;
      r_arready <= (w_rstate_next == R_IDLE);
      r_rvalid  <= (w_rstate_next == R_DATA);
      if (w_rload) begin
        r_rdata <= w_rbeat_err ? 32'd0 : w_rd_word;
        r_rresp <= w_rbeat_err ? 2'b10 : 2'b00;
      end
    end
  end

  assign awready_o = r_awready;
  assign wready_o  = r_wready;
  assign bvalid_o  = r_bvalid;
  assign bid_o     = r_bid;
  assign bresp_o   = {r_werr, 1'b0};
  assign arready_o = r_arready;
  assign rvalid_o  = r_rvalid;
  assign rid_o     = r_rid;
  assign rdata_o   = r_rdata;
  assign rresp_o   = r_rresp;
  assign rlast_o   = r_rlast;

endmodule

// File: tb/tb_dmac_axi_sram.sv
// Directed testbench for dmac_axi_sram. Inputs are driven 1 ns after each
// rising edge, and outputs are sampled at the same point.
module tb_dmac_axi_sram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awid = '0, wid = '0, arid = '0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  awlen = '0, wstrb = '0, arlen = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0;
  logic        awvalid = 1'b0, wlast = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic        awready_o, wready_o, bvalid_o, arready_o, rlast_o, rvalid_o;
  logic [3:0]  bid_o, rid_o;
  logic [1:0]  bresp_o, rresp_o;
  logic [31:0] rdata_o;

  int checks = 0;
  int errors = 0;

`ifdef AXI_SRAM_ERR_EN
  localparam logic [1:0]  ALIAS_RESP = 2'b10;
  localparam logic [31:0] ALIAS_WORD0 = 32'h0BAD_C0DE;
`else
  localparam logic [1:0]  ALIAS_RESP = 2'b00;
  localparam logic [31:0] ALIAS_WORD0 = 32'hCAFE_F00D;
`endif

  always #5 clk = ~clk;

  dmac_axi_sram #(.MEM_DEPTH_LOG2(14), .ID_W(4)) dut (
    .clk(clk), .rst(rst),
    .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize),
    .awburst_i(awburst), .awvalid_i(awvalid), .awready_o(awready_o),
    .wid_i(wid), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
    .wvalid_i(wvalid), .wready_o(wready_o),
    .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready),
    .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize),
    .arburst_i(arburst), .arvalid_i(arvalid), .arready_o(arready_o),
    .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
    .rvalid_o(rvalid_o), .rready_i(rready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [31:0] addr,
                           input logic [3:0] len, input logic [1:0] burst,
                           input logic [31:0] base, input logic [3:0] strb,
                           input int bdelay, input logic [1:0] exp_resp);
    int n;
    awid = id; awaddr = addr; awlen = len; awsize = 3'b010; awburst = burst;
    awvalid = 1'b1;
    n = 0;
    while (!awready_o && n < 50) begin step(); n++; end
    chk("awready", awready_o, 1);
    step();
    awvalid = 1'b0;
    chk("wready_after_aw", wready_o, 1);
    chk("awready_busy", awready_o, 0);
    for (int i = 0; i <= int'(len); i++) begin
      wid = id; wvalid = 1'b1; wdata = base + i; wstrb = strb;
      wlast = (i == int'(len));
      chk("wready_beat", wready_o, 1);
      step();
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("wready_end", wready_o, 0);
    for (int d = 0; d <= bdelay; d++) begin
      chk("bvalid", bvalid_o, 1);
      chk("bid", bid_o, id);
      chk("bresp", bresp_o, exp_resp);
      if (d == bdelay) bready = 1'b1;
      step();
    end
    bready = 1'b0;
    chk("bvalid_end", bvalid_o, 0);
    $display("WRITE id=%h addr=%h len=%0d burst=%0d bresp=%b", id, addr, len, burst, exp_resp);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst,
                          input logic [31:0] exp_base, input logic [31:0] exp_step,
                          input bit toggle);
    int n, b, t;
    arid = id; araddr = addr; arlen = len; arsize = 3'b010; arburst = burst;
    arvalid = 1'b1;
    n = 0;
    while (!arready_o && n < 50) begin step(); n++; end
    chk("arready", arready_o, 1);
    step();
    arvalid = 1'b0;
    b = 0; t = 0;
    while (b <= int'(len) && t < 200) begin
      rready = toggle ? t[0] : 1'b1;
      chk("rvalid", rvalid_o, 1);
      chk("rdata", rdata_o, exp_base + b * exp_step);
      chk("rlast", rlast_o, (b == int'(len)) ? 32'd1 : 32'd0);
      chk("rid", rid_o, id);
      chk("rresp", rresp_o, 0);
      step();
      if (rready) b++;
      t++;
    end
    rready = 1'b0;
    chk("r_beats", b, int'(len) + 1);
    chk("rvalid_end", rvalid_o, 0);
    $display("READ  id=%h addr=%h len=%0d burst=%0d toggle=%0d", id, addr, len, burst, toggle);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_awready", awready_o, 0);
    chk("rst_wready", wready_o, 0);
    chk("rst_bvalid", bvalid_o, 0);
    chk("rst_bid", bid_o, 0);
    chk("rst_bresp", bresp_o, 0);
    chk("rst_arready", arready_o, 0);
    chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rlast", rlast_o, 0);
    chk("rst_rid", rid_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_rresp", rresp_o, 0);
    rst = 1'b0;
    step();
    chk("awready_post_rst", awready_o, 1);
    chk("arready_post_rst", arready_o, 1);
    $display("RESET released");

    // 16-beat INCR write, then read it back
    axi_write(4'h3, 32'h100, 4'd15, 2'b01, 32'h1000, 4'hF, 0, 2'b00);
    axi_read(4'h5, 32'h100, 4'd15, 2'b01, 32'h1000, 32'd1, 1'b0);

    // Byte-strobed merge
    axi_write(4'h1, 32'h40, 4'd0, 2'b01, 32'h1122_3344, 4'hF, 0, 2'b00);
    axi_write(4'h1, 32'h40, 4'd0, 2'b01, 32'hAABB_CCDD, 4'b0101, 0, 2'b00);
    axi_read(4'h2, 32'h40, 4'd0, 2'b01, 32'h11BB_33DD, 32'd0, 1'b0);

    // Read and write to the same word at the same edge
    axi_write(4'h4, 32'h200, 4'd0, 2'b01, 32'h1234_5678, 4'hF, 0, 2'b00);
    awid = 4'h6; awaddr = 32'h200; awlen = 4'd0; awsize = 3'b010; awburst = 2'b01;
    awvalid = 1'b1;
    chk("col_awready", awready_o, 1);
    step();
    awvalid = 1'b0;
    chk("col_wready", wready_o, 1);
    wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wlast = 1'b1;
    arid = 4'h7; araddr = 32'h200; arlen = 4'd0; arsize = 3'b010; arburst = 2'b01;
    arvalid = 1'b1;
    chk("col_arready", arready_o, 1);
    step();
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    chk("col_rvalid", rvalid_o, 1);
    chk("col_old_data", rdata_o, 32'h1234_5678);
    chk("col_bvalid", bvalid_o, 1);
    chk("col_bid", bid_o, 4'h6);
    rready = 1'b1; bready = 1'b1;
    step();
    rready = 1'b0; bready = 1'b0;
    chk("col_rvalid_end", rvalid_o, 0);
    chk("col_bvalid_end", bvalid_o, 0);
    $display("COLLIDE addr=00000200 old=12345678");
    axi_read(4'h7, 32'h200, 4'd0, 2'b01, 32'hDEAD_BEEF, 32'd0, 1'b0);

    // Backpressure: bready held low, rready toggling
    axi_write(4'h9, 32'h300, 4'd3, 2'b01, 32'h5000, 4'hF, 5, 2'b00);
    axi_read(4'hA, 32'h300, 4'd3, 2'b01, 32'h5000, 32'd1, 1'b1);

    // FIXED bursts hold the address
    axi_write(4'hB, 32'h380, 4'd2, 2'b00, 32'hA0, 4'hF, 0, 2'b00);
    axi_read(4'hC, 32'h380, 4'd0, 2'b01, 32'hA2, 32'd0, 1'b0);
    axi_read(4'hD, 32'h300, 4'd1, 2'b00, 32'h5000, 32'd0, 1'b0);

    // Out-of-range address: aliases to word 0, or errors when checking is enabled
    axi_write(4'h2, 32'h0, 4'd0, 2'b01, 32'h0BAD_C0DE, 4'hF, 0, 2'b00);
    axi_write(4'hE, 32'h0001_0000, 4'd0, 2'b01, 32'hCAFE_F00D, 4'hF, 0, ALIAS_RESP);
    axi_read(4'hF, 32'h0, 4'd0, 2'b01, ALIAS_WORD0, 32'd0, 1'b0);

    // Reset mid-burst: outputs clear at once, committed beats remain
    axi_write(4'h1, 32'h504, 4'd0, 2'b01, 32'h0, 4'hF, 0, 2'b00);
    awid = 4'h8; awaddr = 32'h500; awlen = 4'd3; awsize = 3'b010; awburst = 2'b01;
    awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF;
    step();
    wvalid = 1'b0;
    chk("mid_wready", wready_o, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_wready", wready_o, 0);
    chk("mid_rst_awready", awready_o, 0);
    chk("mid_rst_bvalid", bvalid_o, 0);
    step();
    rst = 1'b0;
    step();
    chk("mid_awready", awready_o, 1);
    $display("RESET mid-burst");
    axi_read(4'h3, 32'h500, 4'd1, 2'b01, 32'h77, 32'hFFFF_FF89, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmac_axi_sram.md
# dmac_axi_sram

Synthesizable AXI3 slave SRAM that sits directly downstream of the DMAC's AXI master port and serves its read bursts (source fetch) and write bursts (destination store). It replaces the behavioural memory model so that DMAC + memory can be synthesized and run in FPGA or emulation. Read and write paths are independent state machines sharing one word-addressed storage array with one read port and one write port.

## Interface
- MEM_DEPTH_LOG2, 14, log2 of storage depth in 32-bit words; default is 16K words = 64 KB
- ID_W, 4, width of AXI ID fields
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- awid_i  input  ID_W  write address ID
- awaddr_i  input  32  write start byte address
- awlen_i  input  4  beats-1 (1..16 beats)
- awsize_i  input  3  beat size; 3'b010 expected
- awburst_i  input  2  00 FIXED, 01 INCR
- awvalid_i / awready_o  in / out  1  AW handshake
- wid_i  input  ID_W  write data ID (ignored)
- wdata_i  input  32  write data
- wstrb_i  input  4  byte enables
- wlast_i  input  1  last beat marker (ignored; beat count is authoritative)
- wvalid_i / wready_o  in / out  1  W handshake
- bid_o  output  ID_W  echoes awid of the burst
- bresp_o  output  2  00 OKAY, 10 SLVERR
- bvalid_o / bready_i  out / in  1  B handshake
- arid_i, araddr_i, arlen_i, arsize_i, arburst_i  input  ID_W/32/4/3/2  as AW
- arvalid_i / arready_o  in / out  1  AR handshake
- rid_o  output  ID_W  echoes arid
- rdata_o  output  32  read data
- rresp_o  output  2  per-beat response
- rlast_o  output  1  high on final beat
- rvalid_o / rready_i  out / in  1  R handshake

## Operation
- Word index = addr[MEM_DEPTH_LOG2+1:2]; addr[1:0] ignored.
- Write FSM: W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: awready_o=1; on AW handshake latch id, addr, len, burst; beat count cleared; go W_DATA.
  - W_DATA: wready_o=1; each W handshake writes enabled bytes of wdata_i; INCR advances addr by 4 (32-bit add, no 4 KB check), FIXED holds; after beat len+1 go W_RESP.
  - W_RESP: bvalid_o=1, bid_o=latched id, bresp_o=accumulated response; held stable until bready_i; on handshake go W_IDLE.
- Read FSM: R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: arready_o=1; on AR handshake latch fields, load rdata_o/rresp_o with beat 0, go R_DATA.
  - R_DATA: rvalid_o=1; rlast_o=1 when beat count == len; on R handshake load next beat into rdata_o (registered), or go R_IDLE after last beat.
- Same-cycle read load and write commit to same word: read returns pre-write value.
- Only 1 outstanding transaction per direction; no interleaving.

## Timing
- Reset values: awready_o=0, wready_o=0, bvalid_o=0, bid_o=0, bresp_o=0, arready_o=0, rvalid_o=0, rlast_o=0, rid_o=0, rdata_o=0, rresp_o=0; FSMs to IDLE; storage not cleared.
- awready_o/arready_o go high the first cycle after rst deasserts.
- AW handshake at edge N -> wready_o high in cycle N+1.
- Last W beat at edge M -> bvalid_o high in cycle M+1.
- AR handshake at edge N -> first rvalid_o in cycle N+1; subsequent beats back-to-back when rready_i held high (1 beat/cycle).
- rst asserted mid-burst: outputs return to reset values immediately; partial writes already committed remain.

## Configuration
- AXI_SRAM_ERR_EN defined: beat whose address has any bit in [31:MEM_DEPTH_LOG2+2] set, or burst with awsize/arsize != 3'b010 or burst type 10/11, gets SLVERR; such write beats are dropped (still accepted); read beats return rdata 0; bresp is SLVERR if any beat erred.
- Undefined: upper address bits ignored (aliasing modulo size), size/burst type treated as 4-byte INCR (FIXED still honoured), all responses OKAY.

## Test plan
- Write INCR len=15 at 0x100, data 0x1000+i, wstrb 4'hF, bready high -> 16 beats accepted, bvalid cycle after last beat, bresp 00, bid = awid 4'h3.
- Read INCR len=15 at 0x100, rready high -> 16 consecutive beats 0x1000..0x100F, rlast only on beat 16, rid = arid.
- Write 0xAABBCCDD wstrb 4'b0101 over 0x11223344 at 0x40 -> read back 0x11BB33DD.
- Read at 0x200 while writing 0xDEADBEEF to 0x200 same edge -> old value returned; later read returns 0xDEADBEEF.
- bready low 5 cycles, rready toggling -> bvalid/bid/bresp and rdata/rlast stable until handshake; no beat lost or repeated.
- With AXI_SRAM_ERR_EN, write to 0x0001_0000 -> bresp 10, location 0x0 unchanged; without macro, same write lands at word 0, bresp 00.
